// File: rtl/sda_reg_pkg.sv
// Shared types and constants for the AXI4-Lite to register-bus bridge.
// Optional ack timeout is enabled with SDA_REG_TIMEOUT_EN.
package sda_reg_pkg;

  localparam int REG_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sda_reg_ack_timer.sv
// Counts cycles spent waiting for regAck; only built with SDA_REG_TIMEOUT_EN.
// expired is asserted during the TimeoutCycles-th enabled cycle.
module sda_reg_ack_timer
  import sda_reg_pkg::*;
#(
  parameter int TimeoutCycles = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == Limit);

endmodule

// File: rtl/sda_reg_bus_ctrl.sv
// AXI4-Lite slave bridged onto the single-master register bus.
// Define SDA_REG_TIMEOUT_EN to answer unacked requests with SLVERR.
module sda_reg_bus_ctrl
  import sda_reg_pkg::*;
#(
  parameter int RegAddrWidth  = 8,
  parameter int TimeoutCycles = 255
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [RegAddrWidth-1:0]   s_awaddr,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  input  logic [REG_DATA_WIDTH-1:0] s_wdata,
  input  logic [3:0]                s_wstrb,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  output logic [1:0]                s_bresp,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  input  logic [RegAddrWidth-1:0]   s_araddr,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [REG_DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      regReq,
  output logic                      regWriteEn,
  output logic [RegAddrWidth-1:0]   regAddr,
  output logic [REG_DATA_WIDTH-1:0] regWData,
  output logic [3:0]                regWStrb,
  input  logic [REG_DATA_WIDTH-1:0] regRData,
  input  logic                      regAck
);

  state_t state;

  logic awHeld;
  logic wHeld;
  logic lastWasWrite;
  logic [RegAddrWidth-1:0]   awAddrQ;
  logic [REG_DATA_WIDTH-1:0] wDataQ;
  logic [3:0]                wStrbQ;

  logic idle;
  logic writeRdy;
  logic readGrant;
  logic writeGrant;
  logic timeout;
  logic [RegAddrWidth-1:0]   wrAddr;
  logic [REG_DATA_WIDTH-1:0] wrData;
  logic [3:0]                wrStrb;
  logic [RegAddrWidth-1:0]   grantAddr;
  logic                      unusedAddrBits;

  // readies are also held low while reset is asserted
  assign idle      = (state == ST_IDLE) && !srst;
  assign s_awready = idle && !awHeld;
  assign s_wready  = idle && !wHeld;
  assign writeRdy  = (awHeld || s_awvalid) && (wHeld || s_wvalid);
  assign s_arready = idle && s_arvalid && (!writeRdy || lastWasWrite);
  assign readGrant  = s_arready;
  assign writeGrant = idle && writeRdy && !readGrant;

  assign wrAddr = awHeld ? awAddrQ : s_awaddr;
  assign wrData = wHeld ? wDataQ : s_wdata;
  assign wrStrb = wHeld ? wStrbQ : s_wstrb;
  assign grantAddr = writeGrant ? wrAddr : s_araddr;
  assign unusedAddrBits = ^grantAddr[1:0];

  always_ff @(posedge clk) begin
    if (srst) begin
      awHeld  <= 1'b0;
      wHeld   <= 1'b0;
      awAddrQ <= '0;
      wDataQ  <= '0;
      wStrbQ  <= '0;
    end else if (writeGrant) begin
      awHeld <= 1'b0;
      wHeld  <= 1'b0;
    end else begin
      if (s_awvalid && s_awready) begin
        awHeld  <= 1'b1;
        awAddrQ <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        wHeld  <= 1'b1;
        wDataQ <= s_wdata;
        wStrbQ <= s_wstrb;
      end
    end
  end

`ifdef SDA_REG_TIMEOUT_EN
  sda_reg_ack_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) uAckTimer (
    .clk    (clk),
    .srst   (srst),
    .clear  (state != ST_REQ),
    .enable (state == ST_REQ),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0 && (TimeoutCycles != 0);
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= ST_IDLE;
      lastWasWrite <= 1'b0;
      regReq       <= 1'b0;
      regWriteEn   <= 1'b0;
      regAddr      <= '0;
      regWData     <= '0;
      regWStrb     <= '0;
      s_bvalid     <= 1'b0;
      s_rvalid     <= 1'b0;
      s_rdata      <= '0;
      s_bresp      <= RESP_OKAY;
      s_rresp      <= RESP_OKAY;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (readGrant || writeGrant) begin
            state        <= ST_REQ;
            regReq       <= 1'b1;
            regWriteEn   <= writeGrant;
            lastWasWrite <= writeGrant;
            regAddr      <= {grantAddr[RegAddrWidth-1:2], 2'b00};
            if (writeGrant) begin
              regWData <= wrData;
              regWStrb <= wrStrb;
            end
          end
        end
        ST_REQ: begin
          // ack takes priority over a timeout expiring in the same cycle
          if (regAck) begin
            state  <= ST_RESP;
            regReq <= 1'b0;
            if (regWriteEn) begin
              s_bvalid <= 1'b1;
              s_bresp  <= RESP_OKAY;
            end else begin
              s_rvalid <= 1'b1;
              s_rdata  <= regRData;
              s_rresp  <= RESP_OKAY;
            end
          end else if (timeout) begin
            state  <= ST_RESP;
            regReq <= 1'b0;
            if (regWriteEn) begin
              s_bvalid <= 1'b1;
              s_bresp  <= RESP_SLVERR;
            end else begin
              s_rvalid <= 1'b1;
              s_rdata  <= '0;
              s_rresp  <= RESP_SLVERR;
            end
          end
        end
        ST_RESP: begin
          if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) begin
            state    <= ST_IDLE;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sda_reg_bus_ctrl.sv
// Directed bench for sda_reg_bus_ctrl with a register-block stub.
// Timeout scenario follows SDA_REG_TIMEOUT_EN.
module tb_sda_reg_bus_ctrl;

`ifdef SDA_REG_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic srst;
  logic s_awvalid, s_awready;
  logic [7:0] s_awaddr;
  logic s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0] s_wstrb;
  logic s_bvalid, s_bready;
  logic [1:0] s_bresp;
  logic s_arvalid, s_arready;
  logic [7:0] s_araddr;
  logic s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0] s_rresp;
  logic regReq, regWriteEn;
  logic [7:0] regAddr;
  logic [31:0] regWData;
  logic [3:0] regWStrb;
  logic [31:0] regRData;
  logic regAck;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sda_reg_bus_ctrl #(
    .RegAddrWidth (8),
    .TimeoutCycles(TMO)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awaddr  (s_awaddr),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bresp   (s_bresp),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_araddr  (s_araddr),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .regReq    (regReq),
    .regWriteEn(regWriteEn),
    .regAddr   (regAddr),
    .regWData  (regWData),
    .regWStrb  (regWStrb),
    .regRData  (regRData),
    .regAck    (regAck)
  );

  // register-block stub: acks two cycles after each regReq rise
  logic ackQ = 1'b0;
  logic injAck = 1'b0;
  logic reqD = 1'b0;
  logic stubEn = 1'b1;
  logic [31:0] stubData = 32'h0;
  int ackDly = 0;
  int reqCount = 0;
  logic        logWe[32];
  logic [7:0]  logAddr[32];
  logic [31:0] logData[32];
  logic [3:0]  logStrb[32];

  assign regAck = ackQ | injAck;
  assign regRData = ackQ ? stubData : (injAck ? 32'hBAD0BAD0 : 32'h0);

  always @(posedge clk) begin
    reqD <= regReq;
    ackQ <= 1'b0;
    if (regReq && !reqD) begin
      if (reqCount < 32) begin
        logWe[reqCount]   <= regWriteEn;
        logAddr[reqCount] <= regAddr;
        logData[reqCount] <= regWData;
        logStrb[reqCount] <= regWStrb;
      end
      reqCount <= reqCount + 1;
      ackDly <= 1;
    end else if (ackDly == 1) begin
      ackDly <= 0;
      ackQ <= stubEn;
    end
  end

  task automatic axiRead(input logic [7:0] a, output logic [31:0] d,
                         output logic [1:0] r, output bit ok);
    int n;
    s_arvalid = 1'b1;
    s_araddr = a;
    #1;
    n = 0;
    while (!s_arready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    ok = s_arready;
    @(negedge clk);
    s_arvalid = 1'b0;
    s_rready = 1'b1;
    #1;
    n = 0;
    while (!s_rvalid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    ok = ok && s_rvalid;
    d = s_rdata;
    r = s_rresp;
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  task automatic axiWrite(input logic [7:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [1:0] r,
                          output bit ok);
    int n;
    bit awHs, wHs;
    s_awvalid = 1'b1;
    s_awaddr = a;
    s_wvalid = 1'b1;
    s_wdata = wd;
    s_wstrb = ws;
    #1;
    n = 0;
    while ((s_awvalid || s_wvalid) && n < 50) begin
      awHs = s_awvalid && s_awready;
      wHs = s_wvalid && s_wready;
      @(negedge clk);
      if (awHs) s_awvalid = 1'b0;
      if (wHs) s_wvalid = 1'b0;
      #1; n++;
    end
    ok = !(s_awvalid || s_wvalid);
    s_awvalid = 1'b0;
    s_wvalid = 1'b0;
    s_bready = 1'b1;
    n = 0;
    while (!s_bvalid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    ok = ok && s_bvalid;
    r = s_bresp;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic waitArGrant(output bit ok);
    int n;
    #1;
    n = 0;
    while (!s_arready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    ok = s_arready;
  endtask

  task automatic test_reset;
    srst = 1'b1;
    repeat (3) @(negedge clk);
    s_arvalid = 1'b1;
    #1;
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
         regReq, regWriteEn} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=0", {s_awready, s_wready,
               s_arready, s_bvalid, s_rvalid, regReq, regWriteEn});
    end
    checks++;
    if ({regAddr, regWData, regWStrb} !== 44'h0) begin
      errors++;
      $display("FAIL reset_bus got=%h exp=0", {regAddr, regWData, regWStrb});
    end
    checks++;
    if ({s_rdata, s_bresp, s_rresp} !== 36'h0) begin
      errors++;
      $display("FAIL reset_resp got=%h exp=0", {s_rdata, s_bresp, s_rresp});
    end
    s_arvalid = 1'b0;
    @(negedge clk);
    srst = 1'b0;
    #1;
    checks++;
    if ({s_awready, s_wready} !== 2'b11) begin
      errors++;
      $display("FAIL idle_ready got=%b exp=11", {s_awready, s_wready});
    end
    @(negedge clk);
  endtask

  task automatic test_read;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    int base;
    stubEn = 1'b1;
    stubData = 32'h0000000C;
    base = reqCount;
    axiRead(8'h05, d, r, ok);
    checks++;
    if (!ok || reqCount != base + 1) begin
      errors++;
      $display("FAIL read_hs ok=%0d reqs=%0d exp=1", ok, reqCount - base);
    end
    checks++;
    if ({logWe[base], logAddr[base]} !== 9'h004) begin
      errors++;
      $display("FAIL read_bus got we=%b addr=%h exp we=0 addr=04",
               logWe[base], logAddr[base]);
    end
    checks++;
    if (d !== 32'h0000000C || r !== 2'b00) begin
      errors++;
      $display("FAIL read_data got=%h/%b exp=0000000c/00", d, r);
    end
  endtask

  task automatic test_timing;
    int n;
    bit ok;
    stubData = 32'hA5A50001;
    s_rready = 1'b1;
    s_arvalid = 1'b1;
    s_araddr = 8'h10;
    #1;
    ok = s_arready;
    @(negedge clk);
    s_arvalid = 1'b0;
    #1;
    checks++;
    if (!ok || regReq !== 1'b1 || regAddr !== 8'h10) begin
      errors++;
      $display("FAIL req_rise got ok=%0d req=%b addr=%h exp 1/1/10",
               ok, regReq, regAddr);
    end
    n = 1;
    while (!s_rvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL resp_latency got=%0d exp=4", n);
    end
    checks++;
    if (regReq !== 1'b0 || s_rdata !== 32'hA5A50001) begin
      errors++;
      $display("FAIL req_drop got req=%b data=%h exp 0/a5a50001",
               regReq, s_rdata);
    end
    @(negedge clk);
    s_rready = 1'b0;
    #1;
    checks++;
    if (s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_clear got=%b exp=0", s_rvalid);
    end
  endtask

  task automatic test_split_write;
    int base, n;
    base = reqCount;
    s_wvalid = 1'b1;
    s_wdata = 32'h1;
    s_wstrb = 4'hF;
    #1;
    checks++;
    if (s_wready !== 1'b1) begin
      errors++;
      $display("FAIL split_wready got=%b exp=1", s_wready);
    end
    @(negedge clk);
    s_wvalid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (reqCount != base || s_wready !== 1'b0) begin
      errors++;
      $display("FAIL split_hold reqs=%0d wready=%b exp 0/0",
               reqCount - base, s_wready);
    end
    s_awvalid = 1'b1;
    s_awaddr = 8'h00;
    #1;
    checks++;
    if (s_awready !== 1'b1) begin
      errors++;
      $display("FAIL split_awready got=%b exp=1", s_awready);
    end
    @(negedge clk);
    s_awvalid = 1'b0;
    s_bready = 1'b1;
    #1;
    n = 0;
    while (!s_bvalid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || reqCount != base + 1) begin
      errors++;
      $display("FAIL split_resp bvalid=%b bresp=%b reqs=%0d exp 1/00/1",
               s_bvalid, s_bresp, reqCount - base);
    end
    checks++;
    if ({logWe[base], logAddr[base], logData[base], logStrb[base]}
        !== {1'b1, 8'h00, 32'h1, 4'hF}) begin
      errors++;
      $display("FAIL split_bus got we=%b a=%h d=%h s=%h exp 1/00/1/f",
               logWe[base], logAddr[base], logData[base], logStrb[base]);
    end
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic test_arbitration;
    int base;
    logic [31:0] d1, d2;
    logic [1:0] r1, r2, b1, b2;
    bit ok1, ok2, ok3, ok4;
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    stubData = 32'h0000005A;
    base = reqCount;
    fork
      begin
        axiWrite(8'h20, 32'h11, 4'hF, b1, ok1);
        axiWrite(8'h24, 32'h22, 4'h3, b2, ok2);
      end
      begin
        axiRead(8'h30, d1, r1, ok3);
        axiRead(8'h34, d2, r2, ok4);
      end
    join
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4) || reqCount != base + 4) begin
      errors++;
      $display("FAIL arb_done ok=%b reqs=%0d exp 1111/4",
               {ok1, ok2, ok3, ok4}, reqCount - base);
    end
    checks++;
    if ({logWe[base], logWe[base+1], logWe[base+2], logWe[base+3]}
        !== 4'b1010) begin
      errors++;
      $display("FAIL arb_order got=%b exp=1010", {logWe[base],
               logWe[base+1], logWe[base+2], logWe[base+3]});
    end
    checks++;
    if ({logAddr[base], logAddr[base+1], logAddr[base+2], logAddr[base+3]}
        !== 32'h20302434) begin
      errors++;
      $display("FAIL arb_addr got=%h exp=20302434", {logAddr[base],
               logAddr[base+1], logAddr[base+2], logAddr[base+3]});
    end
    checks++;
    if ({logData[base+2], logStrb[base+2]} !== {32'h22, 4'h3}) begin
      errors++;
      $display("FAIL arb_wdata got=%h/%h exp=22/3",
               logData[base+2], logStrb[base+2]);
    end
    checks++;
    if (d1 !== 32'h5A || d2 !== 32'h5A || {r1, r2, b1, b2} !== 8'h00) begin
      errors++;
      $display("FAIL arb_resp got=%h/%h resp=%b exp 5a/5a/0",
               d1, d2, {r1, r2, b1, b2});
    end
  endtask

  task automatic test_backpressure;
    int base, n;
    bit ok;
    stubData = 32'h0BADF00D;
    s_rready = 1'b0;
    s_arvalid = 1'b1;
    s_araddr = 8'h40;
    waitArGrant(ok);
    @(negedge clk);
    s_arvalid = 1'b0;
    #1;
    n = 0;
    while (!s_rvalid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (!ok || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL bp_start ok=%0d rvalid=%b exp 1/1", ok, s_rvalid);
    end
    s_awvalid = 1'b1;
    s_awaddr = 8'h44;
    s_wvalid = 1'b1;
    s_wdata = 32'h77;
    s_wstrb = 4'h1;
    base = reqCount;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== 32'h0BADF00D) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d rvalid=%b data=%h exp 1/0badf00d",
                 i, s_rvalid, s_rdata);
      end
      checks++;
      if (regReq !== 1'b0 || reqCount != base || s_awready !== 1'b0) begin
        errors++;
        $display("FAIL bp_noreq cyc=%0d req=%b awready=%b exp 0/0",
                 i, regReq, s_awready);
      end
    end
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    #1;
    checks++;
    if (s_awready !== 1'b1 || s_wready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got=%b exp=11", {s_awready, s_wready});
    end
    @(negedge clk);
    s_awvalid = 1'b0;
    s_wvalid = 1'b0;
    s_bready = 1'b1;
    #1;
    n = 0;
    while (!s_bvalid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (s_bvalid !== 1'b1 || reqCount != base + 1 || logWe[base] !== 1'b1) begin
      errors++;
      $display("FAIL bp_write bvalid=%b reqs=%0d exp 1/1",
               s_bvalid, reqCount - base);
    end
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic test_reset_in_req;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    stubData = 32'h12345678;
    s_arvalid = 1'b1;
    s_araddr = 8'h50;
    waitArGrant(ok);
    @(negedge clk);
    s_arvalid = 1'b0;
    s_rready = 1'b1;
    s_bready = 1'b1;
    #1;
    checks++;
    if (!ok || regReq !== 1'b1) begin
      errors++;
      $display("FAIL rst_req_pre ok=%0d req=%b exp 1/1", ok, regReq);
    end
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    #1;
    checks++;
    if (regReq !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_drop got=%b exp=0", regReq);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({s_rvalid, s_bvalid, regReq} !== 3'b000) begin
        errors++;
        $display("FAIL rst_no_resp cyc=%0d got=%b exp=000",
                 i, {s_rvalid, s_bvalid, regReq});
      end
    end
    s_rready = 1'b0;
    s_bready = 1'b0;
    @(negedge clk);
    axiRead(8'h54, d, r, ok);
    checks++;
    if (!ok || d !== 32'h12345678 || r !== 2'b00) begin
      errors++;
      $display("FAIL rst_recover ok=%0d got=%h/%b exp 12345678/00", ok, d, r);
    end
  endtask

  task automatic test_timeout;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    stubEn = 1'b0;
`ifdef SDA_REG_TIMEOUT_EN
    axiRead(8'h60, d, r, ok);
    checks++;
    if (!ok || r !== 2'b10 || d !== 32'h0) begin
      errors++;
      $display("FAIL tmo_resp ok=%0d got=%h/%b exp 0/10", ok, d, r);
    end
    repeat (2) @(negedge clk);
    injAck = 1'b1;
    @(negedge clk);
    injAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({s_rvalid, s_bvalid, regReq} !== 3'b000) begin
        errors++;
        $display("FAIL tmo_late_ack cyc=%0d got=%b exp=000",
                 i, {s_rvalid, s_bvalid, regReq});
      end
    end
`else
    s_arvalid = 1'b1;
    s_araddr = 8'h60;
    waitArGrant(ok);
    @(negedge clk);
    s_arvalid = 1'b0;
    s_rready = 1'b1;
    repeat (1000) @(negedge clk);
    #1;
    checks++;
    if (!ok || regReq !== 1'b1 || s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL no_tmo_wait ok=%0d req=%b rvalid=%b exp 1/1/0",
               ok, regReq, s_rvalid);
    end
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    s_rready = 1'b0;
    @(negedge clk);
`endif
    stubEn = 1'b1;
    stubData = 32'hCAFE0002;
    axiRead(8'h64, d, r, ok);
    checks++;
    if (!ok || d !== 32'hCAFE0002 || r !== 2'b00) begin
      errors++;
      $display("FAIL tmo_recover ok=%0d got=%h/%b exp cafe0002/00", ok, d, r);
    end
  endtask

  initial begin
    srst = 1'b1;
    s_awvalid = 1'b0;
    s_awaddr = '0;
    s_wvalid = 1'b0;
    s_wdata = '0;
    s_wstrb = '0;
    s_bready = 1'b0;
    s_arvalid = 1'b0;
    s_araddr = '0;
    s_rready = 1'b0;
    test_reset();
    test_read();
    test_timing();
    test_split_write();
    test_arbitration();
    test_backpressure();
    test_reset_in_req();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
